fetch_prefetch: RTL

Parametrised successor to the single-register fetch stage. It decouples the PC generator from the instruction memory with a valid/ready request channel and an in-order response channel. Up to MAX_OUTST requests may be in flight, and fetched {pc, insn} pairs are buffered in a QDEPTH-entry queue that feeds decode through a valid/ready handshake. A redirect (branch/jump/trap) flushes the queue and silently discards wrong-path responses still in flight.

---
 rtl/fetch_prefetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch
// Purpose  : Prefetching instruction fetch stage. Issues word-aligned fetch
//            requests to instruction memory over a valid/ready channel, keeps
//            up to MAX_OUTST requests in flight, and buffers the in-order
//            responses as {pc, insn} pairs in a QDEPTH-entry queue that feeds
//            decode. A redirect flushes the queue and drops the wrong-path
//            responses that are still in flight.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            redirect_i/_pc_i      - redirect fetch to a new PC (bits [1:0] ignored)
//            imem_req_*            - request channel (valid/ready/addr)
//            imem_rsp_*            - in-order response channel (valid/data)
//            dec_*                 - queue head to decode (valid/ready/pc/insn)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch #(
    parameter int                 DWIDTH    = 32,
    parameter int                 AWIDTH    = 32,
    // Default matches the instruction memory base address.
    parameter logic [AWIDTH-1:0]  RESET_PC  = AWIDTH'(32'h0100_0000),
    parameter int                 QDEPTH    = 4,
    parameter int                 MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [AWIDTH-1:0] dec_pc_o,
    output logic [DWIDTH-1:0] dec_insn_o
);

    localparam int                QAW      = $clog2(QDEPTH);
    localparam int                CW       = $clog2(QDEPTH + 1);
    localparam int                TW       = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [DWIDTH-1:0] INSN_NOP = DWIDTH'(32'h0000_0013);
    localparam logic [CW:0]       QDEPTH_C = (CW+1)'(QDEPTH);
    localparam logic [CW-1:0]     MAXO_C   = CW'(MAX_OUTST);
    localparam logic [TW-1:0]     TLAST_C  = TW'(MAX_OUTST - 1);

    // Registered state
    logic [AWIDTH-1:0] fpc_q,     fpc_d;
    logic [CW-1:0]     count_q,   count_d;
    logic [CW-1:0]     outst_q,   outst_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [QAW-1:0]    qwr_q,     qwr_d;
    logic [QAW-1:0]    qrd_q,     qrd_d;
    logic [TW-1:0]     twr_q,     twr_d;
    logic [TW-1:0]     trd_q,     trd_d;

    // Storage (no reset needed: occupancy is tracked by the counters)
    logic [AWIDTH-1:0] q_pc_q   [QDEPTH];
    logic [DWIDTH-1:0] q_insn_q [QDEPTH];
    logic [AWIDTH-1:0] tag_q    [MAX_OUTST];

    logic [CW:0] credit;
    logic        fire;
    logic        rsp_acc;
    logic        push;
    logic        pop;

    // Entries that will eventually occupy the queue: those already queued
    // plus live (non-discarded) requests in flight. A same-cycle pop is not
    // credited, which keeps the queue from ever overflowing.
    assign credit = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, discard_q};

    assign imem_req_valid_o = !rst && !redirect_i && (outst_q < MAXO_C) && (credit < QDEPTH_C);
    assign imem_req_addr_o  = fpc_q;
    assign fire             = imem_req_valid_o && imem_req_ready_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_acc = imem_rsp_valid_i && (outst_q != '0);
    assign push    = rsp_acc && (discard_q == '0) && !redirect_i;

    assign dec_valid_o = !rst && (count_q != '0) && !redirect_i;
    assign pop         = dec_valid_o && dec_ready_i;
    assign dec_pc_o    = (count_q != '0) ? q_pc_q[qrd_q]   : '0;
    assign dec_insn_o  = (count_q != '0) ? q_insn_q[qrd_q] : INSN_NOP;

    always_comb begin
        fpc_d     = fpc_q;
        count_d   = count_q;
        outst_d   = outst_q + CW'(fire) - CW'(rsp_acc);
        discard_d = discard_q;
        qwr_d     = qwr_q;
        qrd_d     = qrd_q;
        twr_d     = twr_q;
        trd_d     = trd_q;

        if (fire) begin
            fpc_d = fpc_q + AWIDTH'(4);
            twr_d = (twr_q == TLAST_C) ? '0 : twr_q + TW'(1);
        end
        // Every accepted response retires its tag, kept or dropped.
        if (rsp_acc) begin
            trd_d = (trd_q == TLAST_C) ? '0 : trd_q + TW'(1);
            if (discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
        end

        if (redirect_i) begin
            fpc_d     = redirect_pc_i & ~AWIDTH'(3);
            // Everything still in flight after this cycle is wrong-path.
            discard_d = outst_q - CW'(rsp_acc);
            count_d   = '0;
            qwr_d     = '0;
            qrd_d     = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) begin
                qwr_d = qwr_q + QAW'(1);
            end
            if (pop) begin
                qrd_d = qrd_q + QAW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q     <= RESET_PC;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            qwr_q     <= '0;
            qrd_q     <= '0;
            twr_q     <= '0;
            trd_q     <= '0;
        end else begin
            fpc_q     <= fpc_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            qwr_q     <= qwr_d;
            qrd_q     <= qrd_d;
            twr_q     <= twr_d;
            trd_q     <= trd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            tag_q[twr_q] <= fpc_q;
        end
        if (push) begin
            q_pc_q[qwr_q]   <= tag_q[trd_q];
            q_insn_q[qwr_q] <= imem_rsp_data_i;
        end
    end

endmodule
`default_nettype wire
